// File: rtl/tdc_seq_pkg.sv
// Shared types and default sizing for the TDC hit/clear stimulus sequencer.
// The wait-for-result timeout is enabled by defining TDC_SEQ_TIMEOUT_EN.
package tdc_seq_pkg;

    localparam int SHOT_W_DEF      = 8;
    localparam int GAP_W_DEF       = 16;
    localparam int HIT_LEN_DEF     = 1;
    localparam int CLR_LEN_DEF     = 1;
    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        WAIT_RES,
        CLEAR,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/tdc_seq_timer.sv
// Loadable down-counter with a zero flag. One instance serves every timed
// sequencer state, since those states never overlap.
module tdc_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tdc_stim_sequencer.sv
// Burst scheduler for the TDC hit/clear stimulus path (start/busy/done control).
// Define TDC_SEQ_TIMEOUT_EN to bound the wait for tdc_valid and flag timeouts.
module tdc_stim_sequencer
    import tdc_seq_pkg::*;
#(
    parameter int SHOT_W      = SHOT_W_DEF,
    parameter int GAP_W       = GAP_W_DEF,
    parameter int HIT_LEN     = HIT_LEN_DEF,
    parameter int CLR_LEN     = CLR_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SHOT_W-1:0] shots_cfg,
    input  logic [GAP_W-1:0]  gap_cfg,
    input  logic              tdc_valid,
    output logic              hit,
    output logic              clear,
    output logic              busy,
    output logic              done,
    output logic [SHOT_W-1:0] shot_cnt,
    output logic              timeout_err
);

    state_t            state_q, state_d;
    logic [SHOT_W-1:0] shots_q, shots_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [SHOT_W-1:0] shot_cnt_q, shot_cnt_d;
    logic              abort_q, abort_d;
    logic              hit_q, hit_d;
    logic              clear_q, clear_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_zero;
    logic [GAP_W-1:0]  tmr_val;
    logic              last_shot;
    logic              wait_expired;

`ifdef TDC_SEQ_TIMEOUT_EN
    logic timeout_q, timeout_d;
    assign wait_expired = tmr_zero;
`else
    assign wait_expired = 1'b0;
`endif

    assign last_shot = (shot_cnt_q == shots_q);

    tdc_seq_timer #(.W(GAP_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shots_q    <= '0;
            gap_q      <= '0;
            shot_cnt_q <= '0;
            abort_q    <= 1'b0;
            hit_q      <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TDC_SEQ_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shots_q    <= shots_d;
            gap_q      <= gap_d;
            shot_cnt_q <= shot_cnt_d;
            abort_q    <= abort_d;
            hit_q      <= hit_d;
            clear_q    <= clear_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef TDC_SEQ_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    // A pending abort is remembered so the clear pulse still completes before DONE.
    always_comb begin
        state_d    = state_q;
        shots_d    = shots_q;
        gap_d      = gap_q;
        shot_cnt_d = shot_cnt_q;
        abort_d    = abort_q;
`ifdef TDC_SEQ_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shots_d    = shots_cfg;
                    gap_d      = gap_cfg;
                    shot_cnt_d = '0;
                    abort_d    = 1'b0;
`ifdef TDC_SEQ_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = (shots_cfg == '0) ? DONE : HIT;
                end
            end
            HIT: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = CLEAR;
                end else if (tmr_zero) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (tdc_valid || wait_expired) begin
                    shot_cnt_d = shot_cnt_q + SHOT_W'(1);
                end
`ifdef TDC_SEQ_TIMEOUT_EN
                if (!tdc_valid && wait_expired) begin
                    timeout_d = 1'b1;
                end
`endif
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (tdc_valid || wait_expired || abort) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (tmr_zero) begin
                    if (abort_q || abort || (gap_q == '0 && last_shot)) begin
                        state_d = DONE;
                    end else if (gap_q == '0) begin
                        state_d = HIT;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (abort || (tmr_zero && last_shot)) begin
                    state_d = DONE;
                end else if (tmr_zero) begin
                    state_d = HIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timer is reloaded on every state entry with that state's duration minus one.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_en   = (state_q != IDLE);
        tmr_val  = '0;
        hit_d    = (state_d == HIT);
        clear_d  = (state_d == CLEAR);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        unique case (state_d)
            HIT:      tmr_val = GAP_W'(HIT_LEN - 1);
            WAIT_RES: tmr_val = GAP_W'(TIMEOUT_CYC - 1);
            CLEAR:    tmr_val = GAP_W'(CLR_LEN - 1);
            GAP:      tmr_val = gap_q - GAP_W'(1);
            default:  tmr_val = '0;
        endcase
    end

    assign hit      = hit_q;
    assign clear    = clear_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign shot_cnt = shot_cnt_q;
`ifdef TDC_SEQ_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
